// File: rtl/butterfly_pkg.sv
// Shared types and funct3 encodings for the butterfly load/store unit.
// Also provides the access-width legality helper used by the FSM.
package butterfly_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_ILLEGAL  = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } lsu_exc_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // 011, 110 and 111 have no load/store meaning.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3[1:0] == 2'b11) || (f3 == 3'b110);
  endfunction

endpackage

// File: rtl/butterfly_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
interface butterfly_lsu_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/butterfly_lsu_data_align.sv
// Combinational lane steering: store byte enables/replicated write data, and
// load byte/halfword extraction with sign or zero extension.
module lsu_data_align
  import butterfly_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] lane_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o         = 4'b1111;
    lane_wdata_o = st_wdata_i;
    case (st_size_i)
      2'b00: begin
        be_o         = 4'b0001 << st_off_i;
        lane_wdata_o = {4{st_wdata_i[7:0]}};
      end
      2'b01: begin
        be_o         = 4'b0011 << st_off_i;
        lane_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Aligned accesses only reach here, so a byte-granular shift covers halfwords too.
  assign shifted = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    load_data_o = rdata_i;
    case (ld_funct3_i)
      F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data_o = {24'd0, shifted[7:0]};
      F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data_o = {16'd0, shifted[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/butterfly_lsu.sv
// Load/store unit between EX/MEM and MEM/WB: drives a req/gnt/rvalid bus,
// stalls the pipeline while an access is in flight, and flags access faults.
module butterfly_lsu
  import butterfly_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        exc_o,
  output logic [1:0]  exc_cause_o,
  butterfly_lsu_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [3:0]       be_q, be_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic             we_q, we_d, timeout_q, timeout_d;

  logic             access, illegal, misalign, stall, exc, req;
  lsu_exc_e         exc_cause;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata, ld_fmt;

  lsu_data_align u_align (
    .st_size_i    (funct3_i[1:0]),
    .st_off_i     (addr_i[1:0]),
    .st_wdata_i   (wdata_i),
    .be_o         (st_be),
    .lane_wdata_o (st_wdata),
    .ld_funct3_i  (funct3_q),
    .ld_off_i     (off_q),
    .rdata_i      (bus.data_rdata_i),
    .load_data_o  (ld_fmt)
  );

  assign access   = mem_read_i | mem_write_i;
  assign illegal  = f3_illegal(funct3_i);
  assign misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                    ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    addr_d      = addr_q;
    off_d       = off_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    load_data_d = load_data_q;
    timeout_d   = 1'b0;
    stall       = 1'b0;
    exc         = 1'b0;
    exc_cause   = EXC_NONE;
    req         = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            exc       = 1'b1;
            exc_cause = EXC_ILLEGAL;
          end else if (misalign) begin
            exc       = 1'b1;
            exc_cause = EXC_MISALIGN;
          end else begin
            stall    = 1'b1;
            addr_d   = {addr_i[31:2], 2'b00};
            off_d    = addr_i[1:0];
            be_d     = st_be;
            wdata_d  = st_wdata;
            we_d     = mem_write_i;
            funct3_d = funct3_i;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        req   = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          timeout_d   = 1'b1;
          load_data_d = '0;
        end else if (bus.data_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving on the final budgeted cycle still completes normally.
        if (bus.data_rvalid_i) begin
          if (!we_q) load_data_d = ld_fmt;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          timeout_d   = 1'b1;
          load_data_d = '0;
        end
      end
      DONE: begin
        exc       = timeout_q;
        exc_cause = timeout_q ? EXC_TIMEOUT : EXC_NONE;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      off_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      load_data_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      load_data_q <= load_data_d;
      timeout_q   <= timeout_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign stall_o          = stall & rst_n_i;
  assign exc_o            = exc & rst_n_i;
  assign exc_cause_o      = rst_n_i ? exc_cause : EXC_NONE;
  assign load_data_o      = load_data_q;
  assign bus.data_req_o   = req;
  assign bus.data_we_o    = we_q;
  assign bus.data_be_o    = be_q;
  assign bus.data_addr_o  = addr_q;
  assign bus.data_wdata_o = wdata_q;

endmodule

// File: tb/tb_butterfly_lsu.sv
// Randomized self-checking bench for butterfly_lsu with an access-level
// reference model and a bench-driven memory responder.
module tb_butterfly_lsu;
  import butterfly_pkg::*;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, load_data_o;
  logic        stall_o, exc_o;
  logic [1:0]  exc_cause_o;

  butterfly_lsu_if bus ();

  butterfly_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .load_data_o (load_data_o),
    .stall_o     (stall_o),
    .exc_o       (exc_o),
    .exc_cause_o (exc_cause_o),
    .bus         (bus)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          txn = 0;
  logic [31:0] model_load = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drop_inputs();
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    funct3_i    = '0;
    addr_i      = '0;
    wdata_i     = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load"},  load_data_o,      0);
    check({tag, "_stall"}, stall_o,          0);
    check({tag, "_exc"},   exc_o,            0);
    check({tag, "_cause"}, exc_cause_o,      0);
    check({tag, "_req"},   bus.data_req_o,   0);
    check({tag, "_we"},    bus.data_we_o,    0);
    check({tag, "_be"},    bus.data_be_o,    0);
    check({tag, "_addr"},  bus.data_addr_o,  0);
    check({tag, "_wdata"}, bus.data_wdata_o, 0);
  endtask

  // gnt_dly / rv_dly < 0 means the bench never answers that phase.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
    int          off, size, stalls, req_cycles, wait_cycles, guard, exp_req;
    bit          illegal, misalign, timeout, done;
    logic [31:0] be_exp, wd_exp, ld_exp, addr_exp, sh;
    off      = int'(addr % 4);
    illegal  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    size     = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    misalign = !illegal && ((addr % size) != 0);
    be_exp   = ((32'd1 << size) - 1) << off;
    wd_exp   = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
               (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    addr_exp = addr - off;
    timeout  = (gnt_dly < 0) || (rv_dly < 0);
    exp_req  = (gnt_dly < 0) ? TO : gnt_dly + 1;
    sh       = rdata >> (8 * off);
    if (timeout)          ld_exp = 0;
    else if (wr)          ld_exp = model_load;
    else if (size == 1) begin
      ld_exp = sh & 32'hFF;
      if (f3 == 3'd0 && ld_exp >= 128) ld_exp = ld_exp + 32'hFFFF_FF00;
    end else if (size == 2) begin
      ld_exp = sh & 32'hFFFF;
      if (f3 == 3'd1 && ld_exp >= 32768) ld_exp = ld_exp + 32'hFFFF_0000;
    end else              ld_exp = rdata;

    txn++;
    @(negedge clk_i);
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = addr; wdata_i = wdata;
    #1;
    if (illegal || misalign) begin
      check("err_exc",   exc_o,          1);
      check("err_cause", exc_cause_o,    illegal ? 2 : 1);
      check("err_stall", stall_o,        0);
      check("err_req",   bus.data_req_o, 0);
      @(negedge clk_i);
      check("err_req_next", bus.data_req_o, 0);
      check("err_stall_next", stall_o, 0);
      drop_inputs();
      #1;
      check("err_exc_clear", exc_o, 0);
      check("err_load_hold", load_data_o, model_load);
      $display("txn %0d rd=%0b wr=%0b f3=%0d addr=%h fault cause=%0d", txn, rd, wr, f3, addr,
               illegal ? 2 : 1);
      return;
    end
    check("idle_stall", stall_o, 1);
    stalls = 1; req_cycles = 0; wait_cycles = 0; guard = 0; done = 0;
    while (!done && guard < 40) begin
      @(negedge clk_i);
      guard++;
      bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = $urandom;
      if (stall_o) begin
        stalls++;
        if (bus.data_req_o) begin
          if (req_cycles == 0) begin
            check("req_addr",  bus.data_addr_o,  addr_exp);
            check("req_be",    bus.data_be_o,    be_exp);
            check("req_we",    bus.data_we_o,    wr);
            if (wr) check("req_wdata", bus.data_wdata_o, wd_exp);
          end
          if (req_cycles == gnt_dly) bus.data_gnt_i = 1'b1;
          else bus.data_rvalid_i = 1'($urandom_range(0, 1));
          req_cycles++;
        end else begin
          if (wait_cycles == rv_dly) begin
            bus.data_rvalid_i = 1'b1;
            bus.data_rdata_i  = rdata;
          end else bus.data_gnt_i = 1'($urandom_range(0, 1));
          wait_cycles++;
        end
      end else begin
        done = 1;
        check("done_stalls", stalls, timeout ? 1 + TO : 3 + gnt_dly + rv_dly);
        check("done_reqcyc", req_cycles, exp_req);
        check("done_exc",    exc_o, timeout);
        check("done_cause",  exc_cause_o, timeout ? 3 : 0);
        check("done_load",   load_data_o, ld_exp);
        check("done_req",    bus.data_req_o, 0);
        check("done_addr",   bus.data_addr_o, addr_exp);
        check("done_be",     bus.data_be_o, be_exp);
        bus.data_rvalid_i = 1'($urandom_range(0, 1));
        drop_inputs();
      end
    end
    if (!done) check("done_reached", 0, 1);
    model_load = ld_exp;
    @(negedge clk_i);
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
    #1;
    check("after_exc",   exc_o, 0);
    check("after_stall", stall_o, 0);
    check("after_load",  load_data_o, model_load);
    $display("txn %0d rd=%0b wr=%0b f3=%0d addr=%h gnt=%0d rv=%0d load=%h stalls=%0d",
             txn, rd, wr, f3, addr, gnt_dly, rv_dly, load_data_o, stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    bit          rd, wr;
    rst_n_i = 1'b0;
    drop_inputs();
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1;

    run_access(1, 0, F3_LW,  32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_access(1, 0, F3_LB,  32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);
    run_access(1, 0, F3_LBU, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1, 0);
    run_access(1, 0, F3_LH,  32'h0000_1002, 32'h0, 32'h80FF_0000, 0, 2);
    run_access(0, 1, F3_SB,  32'h0000_2001, 32'h0000_00A5, 32'h0, 4, 0);
    run_access(0, 1, F3_SH,  32'h0000_2002, 32'h1234_BEEF, 32'h0, 0, 1);
    run_access(1, 0, F3_LW,  32'h0000_1002, 32'h0, 32'h0, 0, 0);
    run_access(1, 0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0, 0);
    run_access(1, 0, F3_LW,  32'h0000_3000, 32'h0, 32'h1111_2222, 0, -1);
    run_access(1, 0, F3_LHU, 32'h0000_3002, 32'h0, 32'h1111_2222, -1, 0);

    // Reset while waiting for the response; a late rvalid must be ignored.
    run_access(1, 0, F3_LW, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 0, 0);
    @(negedge clk_i);
    mem_read_i = 1'b1; funct3_i = F3_LW; addr_i = 32'h0000_5000;
    @(negedge clk_i);
    bus.data_gnt_i = 1'b1;
    @(negedge clk_i);
    bus.data_gnt_i = 1'b0;
    rst_n_i = 1'b0;
    drop_inputs();
    @(negedge clk_i);
    check_all_zero("midreset");
    rst_n_i = 1'b1;
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    bus.data_rvalid_i = 1'b0;
    check("late_rv_stall", stall_o, 0);
    check("late_rv_load",  load_data_o, 0);
    model_load = '0;
    $display("txn reset during WAIT, late rvalid ignored");
    run_access(1, 0, F3_LW, 32'h0000_5000, 32'h0, 32'h0BAD_CAFE, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      if (wr && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      run_access(rd, wr, f3, $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk_i);
        bus.data_gnt_i = 1'($urandom_range(0, 1));
        bus.data_rvalid_i = 1'($urandom_range(0, 1));
        #1;
        check("idle_req", bus.data_req_o, 0);
        check("idle_stall_q", stall_o, 0);
      end
      bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
